// File: rtl/rename_stage.sv
// Register-rename stage: speculative RAT plus circular free list feeding issue_queue.
// Optional macro RENAME_FLUSH_EN adds a committed RAT/head and flush recovery.
module rename_stage #(
   parameter int FREE_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [4:0]  dec_rd,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [2:0]  dec_funct3,
   input  logic [6:0]  dec_funct7,
   input  logic [6:0]  dec_opcode,
   input  logic [31:0] dec_immediate,
   input  logic [5:0]  rob_index,
   input  logic        rob_full,
   input  logic        issue_queue_full,
   input  logic        retire_enable,
   input  logic [5:0]  retire_old_phys_rd,
`ifdef RENAME_FLUSH_EN
   input  logic        flush,
   input  logic [4:0]  retire_arch_rd,
   input  logic [5:0]  retire_phys_rd,
`endif
   output logic        write_enable,
   output logic [5:0]  phys_rd,
   output logic [5:0]  phys_rs1,
   output logic [5:0]  phys_rs2,
   output logic [5:0]  old_phys_rd,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [6:0]  opcode,
   output logic [31:0] immediate,
   output logic [5:0]  ROB_entry_index,
   output logic [5:0]  free_count
);

   logic [5:0] rat [32];
   logic [5:0] free_list [FREE_DEPTH];
   logic [5:0] head;
   logic [5:0] tail;
   logic       flush_now;
   logic       accept;
   logic       pop;
   logic       push;

`ifdef RENAME_FLUSH_EN
   logic [5:0] crat [32];
   logic [5:0] chead;
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   // Pointers carry a wrap bit, so tail - head spans 0..FREE_DEPTH.
   assign free_count = tail - head;
   assign dec_ready  = !rob_full && !issue_queue_full && !flush_now &&
                       (free_count != 6'd0 || dec_rd == 5'd0);
   assign accept     = dec_valid && dec_ready;
   assign pop        = accept && (dec_rd != 5'd0);
   assign push       = retire_enable && (retire_old_phys_rd != 6'd0) &&
                       (free_count != 6'(FREE_DEPTH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) rat[i] <= 6'(i);
         for (int k = 0; k < FREE_DEPTH; k++) free_list[k] <= 6'(32 + k);
         head            <= '0;
         tail            <= 6'(FREE_DEPTH);
         write_enable    <= 1'b0;
         phys_rd         <= '0;
         phys_rs1        <= '0;
         phys_rs2        <= '0;
         old_phys_rd     <= '0;
         funct3          <= '0;
         funct7          <= '0;
         opcode          <= '0;
         immediate       <= '0;
         ROB_entry_index <= '0;
      end else begin
         write_enable <= accept;
         if (push) begin
            free_list[tail[4:0]] <= retire_old_phys_rd;
            tail                 <= tail + 6'd1;
         end
         // Sources read the RAT before this instruction's own rd update.
         if (accept) begin
            phys_rs1        <= rat[dec_rs1];
            phys_rs2        <= rat[dec_rs2];
            funct3          <= dec_funct3;
            funct7          <= dec_funct7;
            opcode          <= dec_opcode;
            immediate       <= dec_immediate;
            ROB_entry_index <= rob_index;
            if (pop) begin
               phys_rd     <= free_list[head[4:0]];
               old_phys_rd <= rat[dec_rd];
               rat[dec_rd] <= free_list[head[4:0]];
               head        <= head + 6'd1;
            end else begin
               phys_rd     <= '0;
               old_phys_rd <= '0;
            end
         end
`ifdef RENAME_FLUSH_EN
         if (flush) begin
            rat  <= crat;
            head <= chead;
         end
`endif
      end
   end

`ifdef RENAME_FLUSH_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) crat[i] <= 6'(i);
         chead <= '0;
      end else if (retire_enable && retire_arch_rd != 5'd0) begin
         crat[retire_arch_rd] <= retire_phys_rd;
         chead                <= chead + 6'd1;
      end
   end
`endif

endmodule

// File: doc/rename_stage.md
# rename_stage

Register-rename stage sitting directly upstream of `issue_queue`. It maps architectural registers x0–x31 to physical registers p0–p63 with a speculative register alias table (RAT) and a circular free list, then presents one renamed instruction per cycle on ports that wire straight into the issue queue's rename-side inputs. Retirement returns superseded physical tags to the free list.

## Interface
- `FREE_DEPTH`, 32: free-list capacity, which equals the physical register count minus 32.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `dec_valid` input 1: decode presents an instruction.
- `dec_ready` output 1: stage accepts the instruction this cycle (combinational).
- `dec_rd`, `dec_rs1`, `dec_rs2` input 5 each: architectural register indices.
- `dec_funct3` input 3, `dec_funct7` input 7, `dec_opcode` input 7, `dec_immediate` input 32: passed through unchanged.
- `rob_index` input 6: ROB slot allocated to the instruction currently offered.
- `rob_full`, `issue_queue_full` input 1 each: downstream back-pressure.
- `retire_enable` input 1: ROB retires an instruction this cycle.
- `retire_old_phys_rd` input 6: tag to free.
- `write_enable` output 1: renamed instruction valid; wired to IQ `write_enable`.
- `phys_rd`, `phys_rs1`, `phys_rs2` output 6 each: renamed tags.
- `old_phys_rd` output 6: previous mapping of rd; sent to the ROB.
- `funct3` output 3, `funct7` output 7, `opcode` output 7, `immediate` output 32, `ROB_entry_index` output 6: registered pass-through.
- `free_count` output 6: number of entries currently in the free list (0–32).

## Operation
- **Accept condition.** `accept = dec_valid & dec_ready`. `dec_ready = !rob_full & !issue_queue_full & (free_count != 0 | dec_rd == 0)`.
- **Source lookup.** On accept, `phys_rs1 <= RAT[dec_rs1]` and `phys_rs2 <= RAT[dec_rs2]`. Lookups read the RAT state *before* this instruction's own update, so `rd == rs1` yields the old mapping.
- **Destination, rd ≠ 0.**
  - `phys_rd` is set to the free-list entry at head.
  - `old_phys_rd` is set to `RAT[dec_rd]`.
  - `RAT[dec_rd]` is updated to the new tag.
  - The head pointer increments.
- **Destination, rd = 0.** x0 is never renamed: `phys_rd = 0`, `old_phys_rd = 0`, no pop.
- **Retire.** When `retire_enable` is high and `retire_old_phys_rd != 0`, push the tag at tail and increment tail. A push of tag 0 is ignored. A push while `free_count == 32` is ignored.
- **Free-list pointers.** Head and tail are 6-bit (bit 5 is the wrap bit). `free_count = tail - head`, computed modulo 64.
- **Simultaneous pop and push.** Both pointers advance and the count is unchanged. A tag pushed this cycle is not poppable until the next cycle.
- **Reset values.**
  - `RAT[i] = i`.
  - Free-list slot k = 32 + k; head = 0, tail = 32, `free_count = 32`.
  - `write_enable` = 0.
  - All other outputs = 0.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears with `write_enable = 1` after edge N for exactly one cycle per accepted instruction.
- Throughput is one instruction per cycle. A back-to-back dependent instruction at edge N+1 sees the RAT update made at edge N.
- `write_enable` falls to 0 in any cycle following a non-accept.
- Outputs other than `write_enable` hold their last value when `write_enable = 0`.
- `dec_ready` responds combinationally to `rob_full`, `issue_queue_full` and `free_count` within the same cycle.
- Reset assertion mid-stream immediately clears `write_enable` and restores the reset values. Any in-flight instruction is dropped.

## Configuration
- **Macro:** `RENAME_FLUSH_EN`.
- **With the macro defined:**
  - Adds ports `flush` (input 1), `retire_arch_rd` (input 5) and `retire_phys_rd` (input 6).
  - Adds a committed RAT (`CRAT`), reset to identity, and a committed head pointer, reset to 0.
  - On each retire with `retire_arch_rd != 0`: `CRAT[retire_arch_rd] <= retire_phys_rd` and the committed head increments.
  - On `flush`: `RAT <= CRAT` and `head <= committed head`. The tail still takes the same-cycle retire push. `write_enable <= 0`, and no accept occurs that cycle (`dec_ready = 0`).
  - Flush takes priority over accept.
- **Without the macro:** none of these ports or state exist, and the behaviour is exactly as described above.

## Test plan
- **Reset:** hold `reset_n = 0` for 2 cycles, then release → `free_count = 32`, `write_enable = 0`, `dec_ready = 1`.
- **First rename:** accept `add x1, x2, x3` with `rob_index = 5` → next cycle `write_enable = 1`, `phys_rd = 32`, `phys_rs1 = 2`, `phys_rs2 = 3`, `old_phys_rd = 1`, `ROB_entry_index = 5`, `free_count = 31`.
- **Dependency:** accept `x1 = x1 + x1`, then `x4 = x1 + x0` back-to-back.
  - First instruction: `phys_rs1 = 1`, `phys_rd = 32`.
  - Second instruction: `phys_rs1 = 32`, `phys_rs2 = 0`, `phys_rd = 33`.
- **Exhaustion:** 32 consecutive accepts with rd ≠ 0.
  - Then `free_count = 0`, `dec_ready = 0` for rd = 5, and `dec_ready = 1` for rd = 0.
  - Retiring `old_phys_rd = 7` gives `free_count = 1`; the next rename gets `phys_rd = 7`.
- **Simultaneous:** pop and retire push of tag 9 in the same cycle → `free_count` unchanged, and tag 9 is popped only after the other queued tags.
- **Back-pressure and flush:**
  - `issue_queue_full = 1` with `dec_valid = 1` → `dec_ready = 0`, `write_enable = 0`, RAT unchanged.
  - With `RENAME_FLUSH_EN`: rename x1 → p32, no retire, then `flush` → a subsequent read of x1 gives `phys_rs1 = 1` and `free_count = 32`.
